// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter: round-robin packet arbiter for the async FIFO write port
// Optional per-grant beat limit enabled by defining FIFO_ARB_BURST_LIMIT_EN.
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_inc,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          grant_valid,
  output logic [IDX_WIDTH-1:0]          grant_idx
);
  typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;
  state_t state;
  logic [IDX_WIDTH-1:0] last_idx, sel;
  logic found, xfer, done;
  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 256)
    $error("fifo_wr_rr_arbiter: parameter out of range");
  always_comb begin
    logic [IDX_WIDTH-1:0] j;
    sel = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IDX_WIDTH'((int'(last_idx) + k) % NUM_REQ);
      if (!found && req_valid[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
  end
  // rst gates the write so a packet abandoned by reset leaves no partial beat
  assign xfer = (state == BUSY) && req_valid[grant_idx] && !fifo_full && !rst;
  assign fifo_inc = xfer;
  assign req_ready = xfer ? NUM_REQ'(1) << grant_idx : '0;
  assign fifo_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST) + 1;
  logic [CW-1:0] beat_cnt;
  assign done = xfer && (req_last[grant_idx] || beat_cnt == CW'(MAX_BURST - 1));
  always_ff @(posedge clk)
    if (rst || state == ARB) beat_cnt <= '0;
    else if (xfer) beat_cnt <= beat_cnt + 1'b1;
`else
  assign done = xfer && req_last[grant_idx];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_valid <= 1'b0;
      grant_idx <= '0;
      last_idx <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (|req_valid) state <= ARB;
        ARB: begin
          state <= found ? BUSY : IDLE;
          grant_valid <= found;
          if (found) grant_idx <= sel;
        end
        BUSY: if (done) begin
          state <= IDLE;
          grant_valid <= 1'b0;
          last_idx <= grant_idx;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
